mem_port_initiator: RTL and testbench

- Initiator side of the dual-port data memory. Turns single load/store requests from the CPU memory stage into the memory's word-addressed port signals: wen/waddr/wdata and ren/raddr/rdata.
- The memory has a 1-cycle registered read and no byte enables. Byte and halfword stores are therefore done as read-modify-write.
- Loads are returned aligned and sign- or zero-extended. Requests and responses use valid/ready handshakes.

---
 rtl/mem_port_pkg.sv | 31 +++
 rtl/mem_port_initiator_if.sv | 40 ++++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_port_initiator.sv | 125 ++++++++++++
 tb/tb_mem_port_initiator.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_pkg.sv
// Shared state encoding, access-size codes and alignment helper for the
// data-memory initiator port.
package mem_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    RESP,
    ERR_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  // Illegal size is reported as misaligned so callers need one test.
  function automatic logic misaligned(input logic [1:0] lane, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_initiator_if.sv
// CPU request/response and memory-port signals of the initiator; master is
// the initiator itself, slave is the CPU + memory environment around it.
interface mem_port_initiator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and
// lane insertion into a read word for sub-word read-modify-write stores.
module mem_lane_align
  import mem_port_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load   = i_word;
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load   = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        o_merged = i_word;
        case (i_lane)
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          2'd3:    o_merged[31:24] = i_wdata[7:0];
          default: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        o_load   = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_merged = i_word;
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      default: begin
        o_load   = i_word;
        o_merged = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_initiator.sv
// Initiator for the word-addressed data memory: one outstanding CPU load or
// store, sub-word stores done as read-modify-write over the 1-cycle read port.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WORDS  = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_initiator_if.master bus
);

  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] LIMIT = IW'(NUM_WORDS);

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [IW-1:0]         r_index;
  logic [1:0]            r_lane;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic [IW-1:0]         w_index_in;
  logic [1:0]            w_lane_in;
  logic                  w_err_in;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_index_in = bus.req_addr[ADDR_WIDTH-1:2];
  assign w_lane_in  = bus.req_addr[1:0];
  assign w_err_in   = misaligned(w_lane_in, bus.req_size) || (w_index_in >= LIMIT);
  assign w_accept   = (r_state == IDLE) && bus.req_valid;

  // One aligner serves both paths: r_wdata is the store data for RMW.
  mem_lane_align u_align (
    .i_word     (bus.mem_rdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_index    <= '0;
      r_lane     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= bus.req_we;
        r_index    <= w_index_in;
        r_lane     <= w_lane_in;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_wdata    <= bus.req_wdata;
        r_rdata    <= '0;
        r_err      <= w_err_in;
      end else if (r_state == MERGE) begin
        if (r_we) r_wdata <= w_merged;
        else      r_rdata <= w_load;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_ren    = 1'b0;
    bus.mem_raddr  = '0;
    bus.mem_wen    = 1'b0;
    bus.mem_waddr  = '0;
    bus.mem_wdata  = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_err_in)                                w_next = ERR_RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) w_next = WR;
          else                                         w_next = RD;
        end
      end
      RD: begin
        bus.mem_ren   = 1'b1;
        bus.mem_raddr = {2'b00, r_index};
        w_next        = MERGE;
      end
      MERGE: begin
        w_next = r_we ? WR : RESP;
      end
      WR: begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = {2'b00, r_index};
        bus.mem_wdata = r_wdata;
        w_next        = RESP;
      end
      RESP, ERR_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = r_rdata;
        bus.resp_err   = r_err;
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Table-driven bench for mem_port_initiator with a behavioural memory and a
// response scoreboard, plus back-pressure and mid-operation reset sequences.
module tb_mem_port_initiator;
  import mem_port_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_mw;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  localparam logic [159:0] RST_PAT = {27'd0, 1'b1, 132'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_port_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:127];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)            mem[pl_addr] <= pl_data;
    else if (bus.mem_wen) mem[bus.mem_waddr[6:0]] <= bus.mem_wdata;
    if (bus.mem_ren)      bus.mem_rdata <= mem[bus.mem_raddr[6:0]];
  end

  int          ren_total = 0;
  int          wen_total = 0;
  int          overlap = 0;
  int          bad_phase = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  always @(negedge clk) begin
    if (bus.mem_ren) ren_total++;
    if (bus.mem_wen) begin
      wen_total++;
      last_waddr = bus.mem_waddr;
      last_wdata = bus.mem_wdata;
    end
    if (bus.mem_ren && bus.mem_wen) overlap++;
    if ((bus.mem_ren || bus.mem_wen) && (bus.resp_valid || bus.req_ready)) bad_phase++;
  end

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] outs();
    return {27'd0, bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err,
            bus.mem_ren, bus.mem_raddr, bus.mem_wen, bus.mem_waddr, bus.mem_wdata};
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata, input logic [31:0] rd,
                              input logic err, input int lat, input logic [31:0] mw);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_mw = mw;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_addr     = v.addr;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_wdata    = v.wdata;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_req(input vec_t v);
    int   n;
    int   lat;
    int   r0;
    int   w0;
    int   exp_ren;
    int   exp_wen;
    exp_t e;
    exp_t got;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", bus.req_ready, 1);
    drive(v);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    sbq.push_back(e);
    r0 = ren_total;
    w0 = wen_total;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(lat);
    if (!bus.resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp_valid expected resp within 20 cycles addr=%0h", v.addr);
      void'(sbq.pop_front());
      return;
    end
    got.rdata = bus.resp_rdata; got.err = bus.resp_err; got.lat = lat;
    e = sbq.pop_front();
    chk("resp_rdata", got.rdata, e.rdata);
    chk("resp_err", got.err, e.err);
    chk("resp_latency", got.lat, e.lat);
    @(posedge clk); #1;
    chk("req_ready_after_hs", {bus.req_ready, bus.resp_valid}, 2'b10);
    exp_ren = (!v.exp_err && (!v.we || v.size != SZ_WORD)) ? 1 : 0;
    exp_wen = (!v.exp_err && v.we) ? 1 : 0;
    chk("ren_cycles", ren_total - r0, exp_ren);
    chk("wen_cycles", wen_total - w0, exp_wen);
    if (exp_wen == 1) begin
      chk("mem_waddr", last_waddr, {2'b00, v.addr[31:2]});
      chk("mem_wdata", last_wdata, v.exp_mw);
    end
  endtask

  initial begin
    int   lat;
    int   w0;
    exp_t e;
    vec_t v;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", outs(), RST_PAT);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = i[6:0];
      pl_data = (i == 5) ? 32'h80FF_7F01 : (i == 127) ? 32'hCAFE_F00D : 32'h0;
    end
    @(negedge clk);
    pl_en = 1'b0;
    chk("reset_hold_outputs", outs(), RST_PAT);
    rst_n = 1'b1;

    //            we    addr      size        uns   wdata         rdata         err   lat mw
    vecs.push_back(mk(1'b0, 32'h15, SZ_BYTE, 1'b0, 32'h0, 32'h0000_007F, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h15, SZ_BYTE, 1'b1, 32'h0, 32'h0000_007F, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h17, SZ_BYTE, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h17, SZ_BYTE, 1'b1, 32'h0, 32'h0000_0080, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h16, SZ_HALF, 1'b0, 32'h0, 32'hFFFF_80FF, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h14, SZ_HALF, 1'b0, 32'h0, 32'h0000_7F01, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h16, SZ_HALF, 1'b1, 32'h0, 32'h0000_80FF, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h14, SZ_WORD, 1'b0, 32'h0, 32'h80FF_7F01, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b1, 32'h14, SZ_WORD, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 2, 32'h1122_3344));
    vecs.push_back(mk(1'b1, 32'h16, SZ_HALF, 1'b0, 32'hFFFF_BEEF, 32'h0, 1'b0, 4, 32'hBEEF_3344));
    vecs.push_back(mk(1'b0, 32'h14, SZ_WORD, 1'b0, 32'h0, 32'hBEEF_3344, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b1, 32'h08, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 32'h09, SZ_BYTE, 1'b0, 32'h1234_56A5, 32'h0, 1'b0, 4, 32'hDEAD_A5EF));
    vecs.push_back(mk(1'b0, 32'h08, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_A5EF, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0B, SZ_BYTE, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h1FC, SZ_WORD, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 32'h0));
    vecs.push_back(mk(1'b0, 32'h06, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h0));
    vecs.push_back(mk(1'b0, 32'h03, SZ_HALF, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h0));
    vecs.push_back(mk(1'b0, 32'h00, SZ_ILLEGAL, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h0));
    vecs.push_back(mk(1'b0, 32'h200, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0A, SZ_WORD, 1'b0, 32'h5555_5555, 32'h0, 1'b1, 1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h200, SZ_BYTE, 1'b0, 32'h0000_0055, 32'h0, 1'b1, 1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0A, SZ_HALF, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 4, 32'h1234_A5EF));
    vecs.push_back(mk(1'b0, 32'h0A, SZ_HALF, 1'b1, 32'h0, 32'h0000_1234, 1'b0, 3, 32'h0));

    foreach (vecs[i]) run_req(vecs[i]);

    // Back-pressure: response must hold for 5 cycles with resp_ready low.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    drive(mk(1'b0, 32'h14, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0));
    e.rdata = 32'hBEEF_3344; e.err = 1'b0; e.lat = 3;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(lat);
    chk("stall_latency", lat, 3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_hold", {bus.resp_valid, bus.req_ready, bus.resp_rdata}, {2'b10, 32'hBEEF_3344});
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    e = sbq.pop_front();
    chk("stall_rdata", {bus.resp_err, bus.resp_rdata}, {e.err, e.rdata});
    @(posedge clk); #1;
    chk("stall_release", {bus.req_ready, bus.resp_valid}, 2'b10);

    // Reset during MERGE of a byte store must leave memory untouched.
    w0 = wen_total;
    @(negedge clk);
    drive(mk(1'b1, 32'h08, SZ_BYTE, 1'b0, 32'h0000_0077, 32'h0, 1'b0, 0, 32'h0));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("abort_rd_phase", bus.mem_ren, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("abort_outputs", outs(), RST_PAT);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_mem_word", mem[2], 32'h1234_A5EF);
    chk("abort_no_write", wen_total - w0, 0);

    v = mk(1'b0, 32'h08, SZ_WORD, 1'b0, 32'h0, 32'h1234_A5EF, 1'b0, 3, 32'h0);
    run_req(v);
    v = mk(1'b1, 32'h08, SZ_BYTE, 1'b0, 32'h0000_0077, 32'h0, 1'b0, 4, 32'h1234_A577);
    run_req(v);
    v = mk(1'b0, 32'h08, SZ_BYTE, 1'b0, 32'h0, 32'h0000_0077, 1'b0, 3, 32'h0);
    run_req(v);

    chk("scoreboard_empty", sbq.size(), 0);
    chk("ren_wen_overlap", overlap, 0);
    chk("mem_access_in_idle_resp", bad_phase, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1);
  end

endmodule
